switch_debounce_sync: RTL and testbench
=======================================

// Module: switch_debounce_sync
// PURPOSE
//   Input conditioner for raw board switches: 2-flop synchronizer, then a
//   per-bit stability counter (debouncer) and a change detector.
//   Sits directly upstream of the switch-driven LED logic. Drives its
//   {sel, sw} bus with clean, glitch-free, clock-aligned values.
//   Emits a one-cycle pulse plus a bit mask whenever the clean bus changes.
// PARAMETERS
//   WIDTH       8   number of switch bits conditioned ({sel, sw[6:0]})
//   STABLE_CNT  4   consecutive synchronized cycles a new level must hold (>=1)
//   CNT_W       3   per-bit counter width; must satisfy 2**CNT_W > STABLE_CNT-1
// PORTS
//   clk          in   1      system clock, all logic on posedge
//   rst          in   1      asynchronous, active-high reset
//   raw_in       in   WIDTH  raw switch levels, asynchronous to clk
//   clean_out    out  WIDTH  debounced, synchronized switch levels
//   changed      out  1      1-cycle pulse on the edge clean_out updates
//   change_mask  out  WIDTH  bits of clean_out that toggled; valid with changed
// BEHAVIOUR
//   Reset (async assert, sync release at next posedge):
//   - sync1, sync2, clean_out, all counters, changed, change_mask -> 0.
//   Synchronizer:
//   - sync1 <= raw_in; sync2 <= sync1. No logic between the two flops.
//   Per-bit debounce state, bit i, evaluated each posedge:
//   - IDLE when sync2[i] == clean_out[i]: cnt[i] <= 0.
//   - COUNT when sync2[i] != clean_out[i] and cnt[i] < STABLE_CNT-1:
//     cnt[i] <= cnt[i]+1.
//   - COMMIT when sync2[i] != clean_out[i] and cnt[i] == STABLE_CNT-1:
//     clean_out[i] <= sync2[i]; cnt[i] <= 0.
//   - A mismatch that disappears before COMMIT returns the bit to IDLE.
//     The count restarts from 0 on the next mismatch; partial counts are
//     never kept.
//   - cnt[i] never exceeds STABLE_CNT-1 and never wraps.
//   Latency:
//   - Edge 0 is the edge that first captures a new level into sync1.
//   - If raw_in is held, clean_out updates at edge STABLE_CNT+1
//     (edge 5 for the defaults).
//   - STABLE_CNT=1 gives the minimum latency: edge 2.
//   Change detect (registered, same edge as COMMIT):
//   - change_mask[i] <= 1 for every bit committing on this edge, else 0.
//   - changed <= |(committing bits).
//   - Both are high for exactly one cycle, then return to 0 unless another
//     commit occurs.
//   Simultaneous events:
//   - Several bits committing on one edge produce a single changed pulse
//     with all their mask bits set.
//   - Bits committing on different edges produce separate pulses.
//   Reset mid-operation:
//   - All state clears immediately, including outputs.
//   - After release, clean_out restarts at 0. Any raw bit at 1 is treated
//     as a new change: it commits after the full latency and pulses changed.
//   Combinational path raw_in -> any output: none; all outputs are registered.
// TESTING (WIDTH=8, STABLE_CNT=4)
//   1. rst=1, raw_in=8'hFF for 10 cycles
//      -> clean_out=8'h00, changed=0, change_mask=8'h00 throughout.
//   2. raw_in 8'h00->8'h01, held
//      -> clean_out=8'h01 at edge 5 after capture;
//         changed=1 and change_mask=8'h01 for exactly 1 cycle.
//   3. raw_in[1] high for 3 cycles, then low
//      -> clean_out stays 8'h01; changed never asserts.
//   4. raw_in 8'h01->8'h80 in one cycle
//      -> one changed pulse, change_mask=8'h81, clean_out=8'h80.
//   5. raw_in 8'h80->8'h84; assert rst 2 cycles into the count; release;
//      hold 8'h84
//      -> outputs 0 during rst; clean_out=8'h84 at edge 5 after release;
//         change_mask=8'h84.
//   6. Walk raw_in 8'h01,8'h03,8'h07,...,8'hFF, 8 cycles per step
//      -> each step commits; one pulse per step; mask = the single new bit.

Source files
------------

// File: rtl/switch_debounce_sync.sv
// Switch input conditioner: two-flop synchronizer, per-bit stability counter,
// and a registered change detector that pulses once per update of clean_out.
module switch_debounce_sync #(
    parameter int WIDTH      = 8,
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic             changed,
    output logic [WIDTH-1:0] change_mask
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CNT - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] w_commit;

    // A bit commits when it still disagrees after holding for the full count.
    always_comb begin
        w_commit = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_commit[i] = (r_sync2[i] != clean_out[i]) && (r_cnt[i] == LAST_CNT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            clean_out   <= '0;
            changed     <= 1'b0;
            change_mask <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
            // Any return to agreement discards the partial count.
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == clean_out[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_commit[i]) begin
                    clean_out[i] <= r_sync2[i];
                    r_cnt[i]     <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            change_mask <= w_commit;
            changed     <= |w_commit;
        end
    end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Directed-vector bench for switch_debounce_sync (WIDTH=8, STABLE_CNT=4).
// Each vector drives one clock cycle of inputs and checks the outputs after that edge.
module tb_switch_debounce_sync;

    logic       clk;
    logic       rst;
    logic [7:0] raw_in;
    logic [7:0] clean_out;
    logic       changed;
    logic [7:0] change_mask;

    int n_vec;
    int n_err;

    typedef struct {
        logic       rst;
        logic [7:0] raw;
        logic [7:0] clean;
        logic       chg;
        logic [7:0] mask;
    } vec_t;

    vec_t vecs[$];

    switch_debounce_sync #(
        .WIDTH      (8),
        .STABLE_CNT (4),
        .CNT_W      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .raw_in      (raw_in),
        .clean_out   (clean_out),
        .changed     (changed),
        .change_mask (change_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [7:0] raw, input logic [7:0] clean,
                       input logic chg, input logic [7:0] mask);
        vec_t v;
        v.rst   = r;
        v.raw   = raw;
        v.clean = clean;
        v.chg   = chg;
        v.mask  = mask;
        vecs.push_back(v);
    endtask

    task automatic hold(input int n, input logic r, input logic [7:0] raw, input logic [7:0] clean);
        for (int k = 0; k < n; k++) add(r, raw, clean, 1'b0, 8'h00);
    endtask

    // Input held from edge 0: quiet through edge 4, commit at edge 5, quiet after.
    task automatic step(input logic [7:0] raw, input logic [7:0] prev, input logic [7:0] mask);
        hold(5, 1'b0, raw, prev);
        add(1'b0, raw, raw, 1'b1, mask);
        hold(2, 1'b0, raw, raw);
    endtask

    task automatic check(input string name, input logic [7:0] ec, input logic eg, input logic [7:0] em);
        n_vec++;
        if (clean_out !== ec || changed !== eg || change_mask !== em) begin
            n_err++;
            $display("FAIL %s: got clean=%h changed=%b mask=%h, expected clean=%h changed=%b mask=%h",
                     name, clean_out, changed, change_mask, ec, eg, em);
        end
    endtask

    initial begin
        logic [7:0] raw_w;
        int         pulses;
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        raw_in = 8'h00;

        // Reset held with all switches high.
        hold(10, 1'b1, 8'hFF, 8'h00);
        hold(3, 1'b0, 8'h00, 8'h00);
        // Single bit rising.
        step(8'h01, 8'h00, 8'h01);
        add(1'b0, 8'h01, 8'h01, 1'b0, 8'h00);
        // Three-cycle glitch on bit 1 never commits.
        hold(3, 1'b0, 8'h03, 8'h01);
        hold(6, 1'b0, 8'h01, 8'h01);
        // Two bits toggling together give one pulse.
        step(8'h80, 8'h01, 8'h81);
        // Reset two cycles into a count, then full latency after release.
        hold(3, 1'b0, 8'h84, 8'h80);
        hold(2, 1'b1, 8'h84, 8'h00);
        step(8'h84, 8'h00, 8'h84);
        // Return to all-low before the walk.
        step(8'h00, 8'h84, 8'h84);
        // Walking ones: each step adds one bit.
        for (int s = 0; s < 8; s++) begin
            raw_w = 8'((16'd2 << s) - 16'd1);
            step(raw_w, raw_w >> 1, 8'(1 << s));
        end
        // Mismatch of 3, break of 1, then held: count restarts from zero.
        hold(3, 1'b0, 8'hFE, 8'hFF);
        hold(1, 1'b0, 8'hFF, 8'hFF);
        hold(5, 1'b0, 8'hFE, 8'hFF);
        add(1'b0, 8'hFE, 8'hFE, 1'b1, 8'h01);
        hold(2, 1'b0, 8'hFE, 8'hFE);

        @(negedge clk);
        foreach (vecs[i]) begin
            rst    = vecs[i].rst;
            raw_in = vecs[i].raw;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i].clean, vecs[i].chg, vecs[i].mask);
        end

        // Reset asserted mid-count clears outputs without waiting for a clock edge.
        raw_in = 8'h00;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_async_rst", 8'hFE, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        check("async_rst_immediate", 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // All-low input after reset must never produce a change pulse.
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (changed) pulses++;
        end
        n_vec++;
        if (pulses != 0 || clean_out !== 8'h00) begin
            n_err++;
            $display("FAIL post_rst_quiet: got pulses=%0d clean=%h, expected pulses=0 clean=00",
                     pulses, clean_out);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
